cpu_run_ctrl: RTL

- Run controller and program-memory owner for the 4-bit CPU core.
- Holds the 16x8 instruction store and serves combinational fetches from the core's `addr`.
- Arbitrates store writes from an external loader against execution.
- Sequences the core through reset, halt, free-run (clock-divided) and single-step via `cpu_n_reset` and `cpu_en`.

---
 rtl/cpu_run_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller and 16x8 program store for the 4-bit CPU core: loader arbitration, reset/halt/run/step sequencing.
// Optional breakpoint unit enabled by defining CPU_RUN_CTRL_BRKPT_EN.
module cpu_run_ctrl #(
  parameter int RUN_DIV = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [3:0]       ld_addr,
  input  logic [7:0]       ld_data,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             rst_req,
  input  logic [3:0]       cpu_addr,
  output logic [7:0]       cpu_data,
  output logic             cpu_n_reset,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] exec_cnt
`ifdef CPU_RUN_CTRL_BRKPT_EN
  ,
  input  logic             bp_valid,
  input  logic [3:0]       bp_addr,
  output logic             bp_hit
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } run_state_t;

  localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);

  run_state_t cur_state, nxt_state;
  logic [7:0] mem [16];
  logic [7:0] div_cnt;
  logic       run_en;
  logic       bp_trip;
  logic       run_entry;

  assign state       = cur_state;
  assign cpu_data    = mem[cpu_addr];
  assign ld_ready    = (cur_state == S_IDLE) || (cur_state == S_HALT);
  assign cpu_n_reset = (cur_state != S_IDLE);
  assign run_en      = (cur_state == S_RUN) && (div_cnt == DIV_LAST);
  assign run_entry   = (nxt_state == S_RUN) && (cur_state != S_RUN);
  assign cpu_en      = (run_en && !bp_trip) || (cur_state == S_STEP);

`ifdef CPU_RUN_CTRL_BRKPT_EN
  // first_en lets a resume from a breakpoint execute the instruction it stopped on
  logic first_en;

  assign bp_trip = run_en && !first_en && bp_valid && (cpu_addr == bp_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      first_en <= 1'b0;
      bp_hit   <= 1'b0;
    end else begin
      if (run_entry)
        first_en <= 1'b1;
      else if (run_en)
        first_en <= 1'b0;

      if (rst_req)
        bp_hit <= 1'b0;
      else if (bp_trip)
        bp_hit <= 1'b1;
      else if (run_req || step_req)
        bp_hit <= 1'b0;
    end
  end
`else
  assign bp_trip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      cur_state <= S_IDLE;
    else
      cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (rst_req) begin
      nxt_state = S_IDLE;
    end else begin
      case (cur_state)
        S_IDLE: begin
          if (halt_req)      nxt_state = S_HALT;
          else if (step_req) nxt_state = S_STEP;
          else if (run_req)  nxt_state = S_RUN;
        end
        S_HALT: begin
          if (halt_req)      nxt_state = S_HALT;
          else if (step_req) nxt_state = S_STEP;
          else if (run_req)  nxt_state = S_RUN;
        end
        S_RUN: begin
          if (halt_req || bp_trip) nxt_state = S_HALT;
        end
        S_STEP: nxt_state = S_HALT;
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (ld_valid && ld_ready) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Divider restarts on every RUN entry so the first enable lands RUN_DIV cycles after the request
  always_ff @(posedge clk) begin
    if (reset)
      div_cnt <= 8'd0;
    else if (run_entry)
      div_cnt <= 8'd0;
    else if (cur_state == S_RUN)
      div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      exec_cnt <= '0;
    else if (nxt_state == S_IDLE)
      exec_cnt <= '0;
    else if (cpu_en)
      exec_cnt <= exec_cnt + CNT_W'(1);
  end

endmodule
